// File: rtl/cart_dl_source_if.sv
// Bundles the upstream byte stream, the ioctl word-write bus and the
// transfer status signals of cart_dl_source.
//   start           : one-cycle request to begin an image transfer
//   s_valid/s_data/s_last/s_ready : upstream byte handshake
//   ioctl_download/cart_download  : transfer windows
//   ioctl_wr/ioctl_addr/ioctl_dout/ioctl_wait : 16-bit word write bus
//   img_size/done/overflow        : transfer result
// master = the source block, slave = the party driving start/bytes/wait.
interface cart_dl_source_if;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_ready;
  logic        ioctl_download;
  logic        cart_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;
  logic [63:0] img_size;
  logic        done;
  logic        overflow;

  modport master (
    input  start, s_valid, s_data, s_last, ioctl_wait,
    output s_ready, ioctl_download, cart_download, ioctl_wr,
           ioctl_addr, ioctl_dout, img_size, done, overflow
  );

  modport slave (
    output start, s_valid, s_data, s_last, ioctl_wait,
    input  s_ready, ioctl_download, cart_download, ioctl_wr,
           ioctl_addr, ioctl_dout, img_size, done, overflow
  );
endinterface

// File: rtl/cart_dl_source.sv
// Packs an upstream byte stream into little-endian 16-bit words and writes
// them to an ioctl-style sink, waiting for the sink after every word.
// After the last word, cart_download is held for TAIL_CYCLES cycles, then
// done pulses for one cycle.
// Ports:
//   clk_sys : system clock (rising edge)
//   reset   : asynchronous, active-high
//   bus     : cart_dl_source_if.master (byte input, word bus, status)
module cart_dl_source #(
  parameter logic [24:0] MAX_BYTES   = 25'h0800000,
  parameter int unsigned TAIL_CYCLES = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  cart_dl_source_if.master        bus
);

  localparam int unsigned     TW        = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
  localparam logic [TW-1:0]   TAIL_LAST = TW'(TAIL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_WR, S_ARM, S_WAIT, S_TAIL
  } state_t;

  state_t          state_q, state_d;
  logic [24:0]     addr_q, addr_d;
  logic [15:0]     dout_q, dout_d;
  logic [24:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            last_q, last_d;
  logic [TW-1:0]   tail_q, tail_d;
  logic            done_q, done_d;
  logic            full;

  assign full = (count_q == MAX_BYTES);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
      tail_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      tail_q  <= tail_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    tail_d  = tail_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LO;
          addr_d  = '0;
          dout_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          last_d  = 1'b0;
        end
      end

      S_LO: begin
        if (bus.s_valid) begin
          if (full) begin
            // Byte is consumed but dropped; nothing pending, so s_last
            // skips the write path entirely.
            ovf_d = 1'b1;
            if (bus.s_last) begin
              state_d = S_TAIL;
              tail_d  = '0;
            end
          end else begin
            dout_d  = {8'h00, bus.s_data};
            count_d = count_q + 25'd1;
            last_d  = bus.s_last;
            state_d = bus.s_last ? S_WR : S_HI;
          end
        end
      end

      S_HI: begin
        if (bus.s_valid) begin
          if (full) begin
            // Low byte is pending: stay here dropping bytes until s_last,
            // then flush it with a zero high byte.
            ovf_d = 1'b1;
            if (bus.s_last) begin
              state_d = S_WR;
              last_d  = 1'b1;
            end
          end else begin
            dout_d[15:8] = bus.s_data;
            count_d      = count_q + 25'd1;
            last_d       = bus.s_last;
            state_d      = S_WR;
          end
        end
      end

      S_WR:  state_d = S_ARM;

      S_ARM: state_d = S_WAIT;

      S_WAIT: begin
        if (!bus.ioctl_wait) begin
          if (last_q) begin
            state_d = S_TAIL;
            tail_d  = '0;
          end else begin
            addr_d  = addr_q + 25'd2;
            state_d = S_LO;
          end
        end
      end

      S_TAIL: begin
        if (tail_q == TAIL_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          tail_d = tail_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.s_ready        = (state_q == S_LO) || (state_q == S_HI);
  assign bus.ioctl_wr       = (state_q == S_WR);
  assign bus.ioctl_download = (state_q != S_IDLE) && (state_q != S_TAIL);
  assign bus.cart_download  = (state_q != S_IDLE);
  assign bus.ioctl_addr     = addr_q;
  assign bus.ioctl_dout     = dout_q;
  assign bus.img_size       = {39'd0, count_q};
  assign bus.done           = done_q;
  assign bus.overflow       = ovf_q;

endmodule

// File: tb/tb_cart_dl_source.sv
module tb_cart_dl_source;
  localparam int unsigned TAILN = 16;

  typedef logic [7:0]  bq_t[$];
  typedef logic [40:0] wq_t[$];
  typedef struct {
    int          n;
    logic [31:0] bytes;
    int          nwr;
    logic [40:0] w0;
    logic [40:0] w1;
    logic [63:0] size;
  } vec_t;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  cart_dl_source_if b1 ();
  cart_dl_source_if b2 ();

  cart_dl_source #(.TAIL_CYCLES(TAILN)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .bus(b1)
  );
  cart_dl_source #(.MAX_BYTES(25'd4), .TAIL_CYCLES(TAILN)) dut2 (
    .clk_sys(clk_sys), .reset(reset), .bus(b2)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Write capture and TAIL-window counters
  wq_t wq1, wq2;
  int  tail1 = 0;
  int  tail2 = 0;
  always @(negedge clk_sys) begin
    if (b1.ioctl_wr === 1'b1) wq1.push_back({b1.ioctl_addr, b1.ioctl_dout});
    if (b2.ioctl_wr === 1'b1) wq2.push_back({b2.ioctl_addr, b2.ioctl_dout});
    if (b1.cart_download === 1'b1 && b1.ioctl_download === 1'b0) tail1 <= tail1 + 1;
    if (b2.cart_download === 1'b1 && b2.ioctl_download === 1'b0) tail2 <= tail2 + 1;
  end

  // Sink for dut1: busy from the cycle after ioctl_wr for hold1 cycles
  int hold1 = 3;
  initial begin
    b1.ioctl_wait = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (b1.ioctl_wr === 1'b1) begin
        @(posedge clk_sys); #1;
        b1.ioctl_wait = 1'b1;
        repeat (hold1) @(posedge clk_sys);
        #1;
        b1.ioctl_wait = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, summary %0d/%0d", npass, ntot);
    $fatal(1);
  end

  // Reference model: words are consecutive byte pairs of the first
  // min(n, maxb) bytes, odd tail padded with 0x00.
  task automatic model(input bq_t img, input int maxb, output wq_t ex,
                       output logic [63:0] sz, output logic ovf);
    int n;
    logic [7:0] hi;
    n = (img.size() > maxb) ? maxb : img.size();
    ex.delete();
    for (int i = 0; i < n; i += 2) begin
      hi = (i + 1 < n) ? img[i+1] : 8'h00;
      ex.push_back({25'(i), hi, img[i]});
    end
    sz  = 64'(n);
    ovf = (img.size() > maxb);
  endtask

  task automatic cmp_writes(input string nm, input wq_t got, input int base, input wq_t ex);
    chk({nm, "_count"}, 64'(got.size() - base), 64'(ex.size()));
    for (int i = 0; i < ex.size(); i++)
      if (base + i < got.size()) chk(nm, 64'(got[base+i]), 64'(ex[i]));
  endtask

  task automatic chk_zero1(input string p);
    chk({p, "_s_ready"},  64'(b1.s_ready), 64'd0);
    chk({p, "_dl"},       64'(b1.ioctl_download), 64'd0);
    chk({p, "_cart"},     64'(b1.cart_download), 64'd0);
    chk({p, "_wr"},       64'(b1.ioctl_wr), 64'd0);
    chk({p, "_done"},     64'(b1.done), 64'd0);
    chk({p, "_overflow"}, 64'(b1.overflow), 64'd0);
    chk({p, "_addr"},     64'(b1.ioctl_addr), 64'd0);
    chk({p, "_dout"},     64'(b1.ioctl_dout), 64'd0);
    chk({p, "_img_size"}, b1.img_size, 64'd0);
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    bit ok = 1'b0;
    b1.s_valid = 1'b1; b1.s_data = d; b1.s_last = l;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk_sys);
      if (b1.s_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin @(posedge clk_sys); #1; end
    chk("s_ready_seen", 64'(ok), 64'd1);
    b1.s_valid = 1'b0; b1.s_last = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic l);
    bit ok = 1'b0;
    b2.s_valid = 1'b1; b2.s_data = d; b2.s_last = l;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk_sys);
      if (b2.s_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin @(posedge clk_sys); #1; end
    chk("s_ready_seen2", 64'(ok), 64'd1);
    b2.s_valid = 1'b0; b2.s_last = 1'b0;
  endtask

  task automatic wait_done1(output logic [63:0] sz, output logic ovf);
    bit seen = 1'b0;
    logic cd = 1'b1;
    sz = '0; ovf = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk_sys);
      if (b1.done === 1'b1) begin
        seen = 1'b1; sz = b1.img_size; ovf = b1.overflow; cd = b1.cart_download;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_cart_low", 64'(cd), 64'd0);
    @(negedge clk_sys);
    chk("done_one_cycle", 64'(b1.done), 64'd0);
    @(posedge clk_sys); #1;
  endtask

  task automatic wait_done2(output logic [63:0] sz, output logic ovf);
    bit seen = 1'b0;
    sz = '0; ovf = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk_sys);
      if (b2.done === 1'b1) begin
        seen = 1'b1; sz = b2.img_size; ovf = b2.overflow;
      end
    end
    chk("done_seen2", 64'(seen), 64'd1);
    @(posedge clk_sys); #1;
  endtask

  task automatic pulse_start1();
    b1.start = 1'b1; @(posedge clk_sys); #1; b1.start = 1'b0;
  endtask

  task automatic xfer1(input bq_t img, input int unsigned maxgap, input int start_at,
                       output logic [63:0] sz, output logic ovf);
    int t0;
    t0 = tail1;
    pulse_start1();
    for (int k = 0; k < img.size(); k++) begin
      repeat ($urandom_range(maxgap, 0)) begin @(posedge clk_sys); #1; end
      if (k == start_at) pulse_start1();
      send1(img[k], k == img.size() - 1);
    end
    wait_done1(sz, ovf);
    chk("tail_len", 64'(tail1 - t0), 64'(TAILN));
  endtask

  initial begin
    vec_t        tbl[4];
    bq_t         img;
    wq_t         ex;
    logic [63:0] sz, esz;
    logic        ovf, eovf;
    int          base, nw, len;
    logic [40:0] snap;
    bit          ok;

    tbl[0] = '{n:4, bytes:32'h04030201, nwr:2, w0:{25'd0,16'h0201}, w1:{25'd2,16'h0403}, size:64'd4};
    tbl[1] = '{n:3, bytes:32'h00CCBBAA, nwr:2, w0:{25'd0,16'hBBAA}, w1:{25'd2,16'h00CC}, size:64'd3};
    tbl[2] = '{n:1, bytes:32'h0000005A, nwr:1, w0:{25'd0,16'h005A}, w1:41'd0,             size:64'd1};
    tbl[3] = '{n:2, bytes:32'h00002211, nwr:1, w0:{25'd0,16'h2211}, w1:41'd0,             size:64'd2};

    b1.start = 1'b0; b1.s_valid = 1'b0; b1.s_data = '0; b1.s_last = 1'b0;
    b2.start = 1'b0; b2.s_valid = 1'b0; b2.s_data = '0; b2.s_last = 1'b0;
    b2.ioctl_wait = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    #1 chk_zero1("reset");
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    @(posedge clk_sys); #1;

    // Directed table
    hold1 = 3;
    for (int t = 0; t < 4; t++) begin
      img.delete();
      for (int k = 0; k < tbl[t].n; k++) img.push_back(tbl[t].bytes[8*k +: 8]);
      base = wq1.size();
      xfer1(img, 0, -1, sz, ovf);
      ex.delete();
      ex.push_back(tbl[t].w0);
      if (tbl[t].nwr > 1) ex.push_back(tbl[t].w1);
      cmp_writes("tbl_wr", wq1, base, ex);
      chk("tbl_size", sz, tbl[t].size);
      chk("tbl_ovf", 64'(ovf), 64'd0);
    end

    // Long sink stall: everything frozen while ioctl_wait is high
    hold1 = 40;
    base = wq1.size();
    pulse_start1();
    send1(8'h11, 1'b0);
    send1(8'h22, 1'b0);
    @(negedge clk_sys);
    chk("stall_wr_strobe", 64'(b1.ioctl_wr), 64'd1);
    snap = {b1.ioctl_addr, b1.ioctl_dout};
    ok = 1'b1;
    for (int i = 0; i < 38; i++) begin
      @(negedge clk_sys);
      if (b1.ioctl_wr !== 1'b0 || b1.s_ready !== 1'b0 ||
          {b1.ioctl_addr, b1.ioctl_dout} !== snap) ok = 1'b0;
    end
    chk("stall_stable", 64'(ok), 64'd1);
    chk("stall_word", 64'(snap), 64'({25'd0, 16'h2211}));
    @(posedge clk_sys); #1;
    send1(8'h33, 1'b0);
    send1(8'h44, 1'b1);
    wait_done1(sz, ovf);
    ex.delete();
    ex.push_back({25'd0, 16'h2211});
    ex.push_back({25'd2, 16'h4433});
    cmp_writes("stall_wr", wq1, base, ex);
    chk("stall_size", sz, 64'd4);

    // start pulsed mid-transfer is ignored
    hold1 = 2;
    img = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    base = wq1.size();
    xfer1(img, 1, 5, sz, ovf);
    model(img, 32'h0800000, ex, esz, eovf);
    cmp_writes("midstart_wr", wq1, base, ex);
    chk("midstart_size", sz, esz);
    chk("midstart_ovf", 64'(ovf), 64'(eovf));

    // Randomized images against the model
    for (int r = 0; r < 15; r++) begin
      img.delete();
      len = int'($urandom_range(12, 1));
      for (int k = 0; k < len; k++) img.push_back(8'($urandom));
      hold1 = int'($urandom_range(4, 1));
      base = wq1.size();
      xfer1(img, 2, ($urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1, sz, ovf);
      model(img, 32'h0800000, ex, esz, eovf);
      cmp_writes("rnd_wr", wq1, base, ex);
      chk("rnd_size", sz, esz);
      chk("rnd_ovf", 64'(ovf), 64'(eovf));
    end

    // Reset while waiting on the sink
    hold1 = 30;
    pulse_start1();
    send1(8'h10, 1'b0);
    send1(8'h20, 1'b0);
    repeat (4) begin @(posedge clk_sys); #1; end
    chk("pre_reset_wait", 64'(b1.ioctl_wait), 64'd1);
    chk("pre_reset_dl", 64'(b1.ioctl_download), 64'd1);
    reset = 1'b1;
    #1 chk_zero1("rst_wait");
    nw = wq1.size();
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    repeat (10) begin @(posedge clk_sys); #1; end
    chk("no_wr_after_reset", 64'(wq1.size()), 64'(nw));
    repeat (40) begin @(posedge clk_sys); #1; end
    hold1 = 2;
    img = '{8'h5A, 8'h6B};
    base = wq1.size();
    xfer1(img, 0, -1, sz, ovf);
    ex.delete();
    ex.push_back({25'd0, 16'h6B5A});
    cmp_writes("post_reset_wr", wq1, base, ex);

    // Overflow on the MAX_BYTES=4 instance
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    base = wq2.size();
    nw = tail2;
    b2.start = 1'b1; @(posedge clk_sys); #1; b2.start = 1'b0;
    for (int k = 0; k < img.size(); k++) send2(img[k], k == img.size() - 1);
    wait_done2(sz, ovf);
    model(img, 4, ex, esz, eovf);
    cmp_writes("ovf_wr", wq2, base, ex);
    chk("ovf_size", sz, 64'd4);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_tail_len", 64'(tail2 - nw), 64'(TAILN));
    chk("ovf_sticky", 64'(b2.overflow), 64'd1);
    b2.start = 1'b1; @(posedge clk_sys); #1; b2.start = 1'b0;
    @(negedge clk_sys);
    chk("ovf_cleared_by_start", 64'(b2.overflow), 64'd0);
    @(posedge clk_sys); #1;
    base = wq2.size();
    send2(8'hE1, 1'b0);
    send2(8'hF2, 1'b1);
    wait_done2(sz, ovf);
    ex.delete();
    ex.push_back({25'd0, 16'hF2E1});
    cmp_writes("ovf2_wr", wq2, base, ex);
    chk("ovf2_flag", 64'(ovf), 64'd0);
    chk("ovf2_size", sz, 64'd2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
